// File: rtl/store_checker.sv
// store_checker: watches the core's data-memory store stream and reaches a
// pass/fail/timeout verdict, then holds the core via halt.
// Ports:
//   clk          core clock, rising edge
//   reset        asynchronous active-low reset
//   enable       start checking (sampled in IDLE)
//   memwrite     store strobe
//   dataadr      store address
//   writedata    store data
//   halt         verdict reached; core clock-enable is its inverse
//   done         verdict reached (pass, fail or timeout)
//   pass         pass verdict
//   fail         fail or timeout verdict
//   timed_out    timeout verdict
//   store_count  stores accepted while running (saturating)
//   fail_addr    address of the offending store, else 0
//   fail_data    data of the offending store, else 0
//   cycle_count  cycles spent running, frozen at the verdict
module store_checker #(
  parameter logic [31:0] PASS_ADDR    = 32'd84,
  parameter logic [31:0] PASS_DATA    = 32'd7,
  parameter logic [31:0] SCRATCH_ADDR = 32'd80,
  parameter logic [31:0] TIMEOUT      = 32'd10000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic        halt,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timed_out,
  output logic [15:0] store_count,
  output logic [31:0] fail_addr,
  output logic [31:0] fail_data,
  output logic [31:0] cycle_count
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_PASS    = 3'd2,
    S_FAIL    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  state_t state;
  state_t state_next;
  logic   latch_fail_c;
  logic   done_next;
  logic   pass_next;
  logic   fail_next;
  logic   timed_out_next;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: store verdicts take priority over the timeout
  always_comb begin
    state_next   = state;
    latch_fail_c = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (memwrite) begin
          if (dataadr == PASS_ADDR) begin
            if (writedata == PASS_DATA) begin
              state_next = S_PASS;
            end else begin
              state_next   = S_FAIL;
              latch_fail_c = 1'b1;
            end
          end else if (dataadr != SCRATCH_ADDR) begin
            state_next   = S_FAIL;
            latch_fail_c = 1'b1;
          end
        end
        if ((state_next == S_RUN) && (TIMEOUT != 32'd0) &&
            (cycle_count == (TIMEOUT - 32'd1))) begin
          state_next = S_TIMEOUT;
        end
      end
      S_PASS, S_FAIL, S_TIMEOUT: begin
        state_next = state;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Output decode of the upcoming state, registered below
  always_comb begin
    done_next      = 1'b0;
    pass_next      = 1'b0;
    fail_next      = 1'b0;
    timed_out_next = 1'b0;
    case (state_next)
      S_PASS: begin
        done_next = 1'b1;
        pass_next = 1'b1;
      end
      S_FAIL: begin
        done_next = 1'b1;
        fail_next = 1'b1;
      end
      S_TIMEOUT: begin
        done_next      = 1'b1;
        fail_next      = 1'b1;
        timed_out_next = 1'b1;
      end
      default: begin
        done_next = 1'b0;
      end
    endcase
  end

  // Registered verdict flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      halt      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      halt      <= done_next;
      done      <= done_next;
      pass      <= pass_next;
      fail      <= fail_next;
      timed_out <= timed_out_next;
    end
  end

  // Counters and failure capture; only move while running
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      store_count <= '0;
      cycle_count <= '0;
      fail_addr   <= '0;
      fail_data   <= '0;
    end else if (state == S_RUN) begin
      // Cycle count freezes on the verdict edge
      if (state_next == S_RUN) begin
        cycle_count <= cycle_count + 32'd1;
      end
      if (memwrite && (store_count != {CNT_W{1'b1}})) begin
        store_count <= store_count + CNT_W'(1);
      end
      if (latch_fail_c) begin
        fail_addr <= dataadr;
        fail_data <= writedata;
      end
    end
  end

endmodule
